resilient_stage_ctrl: RTL and testbench

//  Clocked controller for one error-detecting (timing-resilient) pipeline stage.
//  - Captures a WIDTH-bit token on a 4-phase left handshake.
//  - Waits a programmable delay, then samples a dual-rail error flag.
//  - Adds RESIL recovery cycles when a timing error is flagged, then issues the token on a 4-phase right handshake.
//  - Sits between datapath stages, next to the error-detecting latch or shadow-sampler.

---
 rtl/resilient_stage_if.sv | 26 ++
 rtl/resilient_stage_ctrl.sv | 114 +++++++++++
 tb/tb_resilient_stage_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/resilient_stage_if.sv
// resilient_stage_if: left/right 4-phase handshake, error-detect and statistics signals of one resilient stage
interface resilient_stage_if #(
  parameter int WIDTH    = 8,
  parameter int ERRCNT_W = 8
);
  logic                Lreq;
  logic                Lack;
  logic [WIDTH-1:0]    Ldata;
  logic                Rreq;
  logic                Rack;
  logic [WIDTH-1:0]    Rdata;
  logic                LEreq;
  logic                sample;
  logic                Err1;
  logic                Err0;
  logic                err_illegal;
  logic [ERRCNT_W-1:0] err_count;
  modport slave (
    input  Lreq, Ldata, Rack, Err1, Err0,
    output Lack, Rreq, Rdata, LEreq, sample, err_illegal, err_count
  );
  modport master (
    output Lreq, Ldata, Rack, Err1, Err0,
    input  Lack, Rreq, Rdata, LEreq, sample, err_illegal, err_count
  );
endinterface

// File: rtl/resilient_stage_ctrl.sv
// resilient_stage_ctrl: timing-resilient stage controller; `define ERR_STATS_EN to build the error counter and illegal flag
module resilient_stage_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DELAY    = 2,
  parameter int RESIL    = 1,
  parameter int ERRCNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  resilient_stage_if.slave  bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DLY    = 3'd1;
  localparam logic [2:0] SAMP   = 3'd2;
  localparam logic [2:0] RECOV  = 3'd3;
  localparam logic [2:0] OUT_UP = 3'd4;
  localparam logic [2:0] OUT_DN = 3'd5;
  localparam int CW = $clog2((DELAY > RESIL ? DELAY : RESIL) + 1);
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lack_q, lack_d;
  logic             rreq_q, rreq_d;
  logic             le_q;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             cap;
  // A capture needs the left side returned to zero and the right side idle (or just leaving OUT_DN)
  assign cap     = bus.Lreq && !lack_q && !bus.Rack && (state_q == IDLE || state_q == OUT_DN);
  assign lack_d  = cap | (lack_q & bus.Lreq);
  assign rdata_d = cap ? bus.Ldata : rdata_q;
  // Right-side FSM: delay, sample window, optional recovery, then output handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rreq_d  = rreq_q;
    case (state_q)
      IDLE, OUT_DN: begin
        if (cap) begin
          state_d = DLY;
          cnt_d   = CW'(DELAY - 1);
        end else if (state_q == OUT_DN && !bus.Rack) state_d = IDLE;
      end
      DLY: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? SAMP : DLY;
      end
      SAMP: begin
        if (bus.Err1) begin
          state_d = RECOV;
          cnt_d   = CW'(RESIL - 1);
        end else if (bus.Err0) begin
          state_d = OUT_UP;
          rreq_d  = 1'b1;
        end
      end
      RECOV: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? OUT_UP : RECOV;
        rreq_d  = (cnt_q == '0);
      end
      OUT_UP: begin
        state_d = bus.Rack ? OUT_DN : OUT_UP;
        rreq_d  = !bus.Rack;
      end
      default: state_d = IDLE;
    endcase
  end
  // State, handshake and token registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lack_q  <= 1'b0;
      rreq_q  <= 1'b0;
      le_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lack_q  <= lack_d;
      rreq_q  <= rreq_d;
      le_q    <= cap;
      rdata_q <= rdata_d;
    end
  end
  assign bus.Lack   = lack_q;
  assign bus.Rreq   = rreq_q;
  assign bus.Rdata  = rdata_q;
  assign bus.LEreq  = le_q;
  assign bus.sample = (state_q == SAMP);
`ifdef ERR_STATS_EN
  logic                err_ev, ill_ev;
  logic [ERRCNT_W-1:0] errc_q, errc_d;
  logic                ill_q, ill_d;
  assign err_ev = (state_q == SAMP) && bus.Err1;
  assign ill_ev = err_ev && bus.Err0;
  assign errc_d = (err_ev && errc_q != '1) ? errc_q + 1'b1 : errc_q;
  assign ill_d  = ill_q | ill_ev;
  // Saturating error counter and sticky illegal-pair flag
  always_ff @(posedge clk) begin
    if (rst) begin
      errc_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      errc_q <= errc_d;
      ill_q  <= ill_d;
    end
  end
  assign bus.err_count   = errc_q;
  assign bus.err_illegal = ill_q;
`else
  assign bus.err_count   = ERRCNT_W'(0);
  assign bus.err_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// tb_resilient_stage_ctrl: scoreboard bench for resilient_stage_ctrl (DELAY=2, RESIL=1, ERRCNT_W=2)
module tb_resilient_stage_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_d;
`ifdef ERR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  resilient_stage_if #(.WIDTH(8), .ERRCNT_W(2)) bus ();
  resilient_stage_ctrl #(.WIDTH(8), .DELAY(2), .RESIL(1), .ERRCNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic capture(input logic [7:0] d, output int k);
    bus.Lreq  = 1'b1;
    bus.Ldata = d;
    sb.push_back(d);
    tick();
    k = cyc;
    bus.Lreq = 1'b0;
  endtask
  task automatic wait_rreq(output int e, output int s);
    e = -1;
    s = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.sample && s < 0) s = cyc;
      if (bus.Rreq) begin
        e = cyc;
        break;
      end
      tick();
    end
  endtask
  task automatic release_out();
    bus.Rack = 1'b1;
    for (int i = 0; i < 20 && bus.Rreq; i++) tick();
    bus.Rack = 1'b0;
    tick();
    tick();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({bus.Lack, bus.Rreq, bus.LEreq, bus.sample, bus.err_illegal} !== 5'b0 || bus.Rdata !== 8'h00 || bus.err_count !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: Lack/Rreq/LEreq/sample/ill=%b Rdata=%h cnt=%0d, want all zero", {bus.Lack, bus.Rreq, bus.LEreq, bus.sample, bus.err_illegal}, bus.Rdata, bus.err_count);
    end
  endtask
  task automatic test_no_error();
    int k, e, s;
    bus.Err0 = 1'b1;
    bus.Err1 = 1'b0;
    capture(8'hA5, k);
    total++;
    if (bus.Lack !== 1'b1 || bus.LEreq !== 1'b1) begin
      bad++;
      $display("FAIL capture_ack: Lack=%b LEreq=%b want 1 1", bus.Lack, bus.LEreq);
    end
    tick();
    total++;
    if (bus.LEreq !== 1'b0) begin
      bad++;
      $display("FAIL lereq_width: LEreq=%b one cycle after capture, want 0", bus.LEreq);
    end
    wait_rreq(e, s);
    total++;
    if (s - k !== 2 || e - k !== 3) begin
      bad++;
      $display("FAIL noerr_latency: sample at +%0d Rreq at +%0d, want +2 +3", s - k, e - k);
    end
    exp_d = sb.pop_front();
    total++;
    if (bus.Rdata !== exp_d) begin
      bad++;
      $display("FAIL noerr_data: Rdata=%h want %h", bus.Rdata, exp_d);
    end
    release_out();
  endtask
  task automatic test_error();
    int k, e, s;
    bus.Err0 = 1'b0;
    bus.Err1 = 1'b1;
    capture(8'h5A, k);
    wait_rreq(e, s);
    total++;
    if (e - k !== 4) begin
      bad++;
      $display("FAIL err_latency: Rreq at +%0d want +4", e - k);
    end
    exp_d = sb.pop_front();
    total++;
    if (bus.Rdata !== exp_d || bus.err_count !== (STATS ? 2'd1 : 2'd0)) begin
      bad++;
      $display("FAIL err_data_count: Rdata=%h cnt=%0d want %h %0d", bus.Rdata, bus.err_count, exp_d, STATS ? 1 : 0);
    end
    release_out();
  endtask
  task automatic test_late_flag();
    int k;
    bus.Err0 = 1'b0;
    bus.Err1 = 1'b0;
    capture(8'hC3, k);
    tick();
    tick();
    repeat (5) tick();
    total++;
    if (bus.sample !== 1'b1 || bus.Rreq !== 1'b0) begin
      bad++;
      $display("FAIL late_wait: sample=%b Rreq=%b want 1 0", bus.sample, bus.Rreq);
    end
    bus.Err0 = 1'b1;
    tick();
    exp_d = sb.pop_front();
    total++;
    if (bus.Rreq !== 1'b1 || bus.sample !== 1'b0 || bus.Rdata !== exp_d) begin
      bad++;
      $display("FAIL late_rreq: Rreq=%b sample=%b Rdata=%h want 1 0 %h", bus.Rreq, bus.sample, bus.Rdata, exp_d);
    end
    release_out();
  endtask
  task automatic test_saturation();
    int k, e, s;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.Err1 = 1'b1;
      bus.Err0 = (i == 3);
      capture(8'(8'h10 + i), k);
      wait_rreq(e, s);
      exp_d = sb.pop_front();
      total++;
      if (e - k !== 4 || bus.Rdata !== exp_d) begin
        bad++;
        $display("FAIL sat_token%0d: Rreq at +%0d Rdata=%h want +4 %h", i, e - k, bus.Rdata, exp_d);
      end
      if (i == 2) begin
        total++;
        if (bus.err_count !== (STATS ? 2'd3 : 2'd0) || bus.err_illegal !== 1'b0) begin
          bad++;
          $display("FAIL sat_three: cnt=%0d ill=%b want %0d 0", bus.err_count, bus.err_illegal, STATS ? 3 : 0);
        end
      end
      release_out();
    end
    total++;
    if (bus.err_count !== (STATS ? 2'd3 : 2'd0) || bus.err_illegal !== STATS) begin
      bad++;
      $display("FAIL sat_illegal: cnt=%0d ill=%b want %0d %b", bus.err_count, bus.err_illegal, STATS ? 3 : 0, STATS);
    end
  endtask
  task automatic test_reset_mid();
    int k, e, s;
    bus.Err1 = 1'b0;
    bus.Err0 = 1'b1;
    capture(8'h3C, k);
    wait_rreq(e, s);
    exp_d = sb.pop_front();
    total++;
    if (bus.Rreq !== 1'b1 || bus.Rdata !== exp_d) begin
      bad++;
      $display("FAIL rst_pre: Rreq=%b Rdata=%h want 1 %h", bus.Rreq, bus.Rdata, exp_d);
    end
    bus.Lreq = 1'b1;
    bus.Ldata = 8'hEE;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.Lreq = 1'b0;
    total++;
    if (bus.Rreq !== 1'b0 || bus.Lack !== 1'b0 || bus.Rdata !== 8'h00 || bus.err_count !== 2'd0 || bus.err_illegal !== 1'b0 || bus.sample !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: Rreq=%b Lack=%b Rdata=%h cnt=%0d ill=%b sample=%b want 0 0 00 0 0 0", bus.Rreq, bus.Lack, bus.Rdata, bus.err_count, bus.err_illegal, bus.sample);
    end
    tick();
  endtask
  task automatic test_backpressure();
    int k, e, s, viol;
    bus.Err1 = 1'b0;
    bus.Err0 = 1'b1;
    capture(8'h11, k);
    wait_rreq(e, s);
    exp_d = sb.pop_front();
    total++;
    if (e - k !== 3 || bus.Rdata !== exp_d) begin
      bad++;
      $display("FAIL bp_first: Rreq at +%0d Rdata=%h want +3 %h", e - k, bus.Rdata, exp_d);
    end
    bus.Lreq = 1'b1;
    bus.Ldata = 8'h22;
    sb.push_back(8'h22);
    viol = 0;
    repeat (10) begin
      tick();
      if (bus.Lack !== 1'b0 || bus.LEreq !== 1'b0 || bus.Rreq !== 1'b1 || bus.Rdata !== 8'h11) viol++;
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL bp_hold: %0d cycles disturbed under backpressure, want 0", viol);
    end
    bus.Rack = 1'b1;
    tick();
    total++;
    if (bus.Rreq !== 1'b0 || bus.Lack !== 1'b0) begin
      bad++;
      $display("FAIL bp_drop: Rreq=%b Lack=%b want 0 0", bus.Rreq, bus.Lack);
    end
    bus.Rack = 1'b0;
    tick();
    k = cyc;
    bus.Lreq = 1'b0;
    total++;
    if (bus.Lack !== 1'b1 || bus.LEreq !== 1'b1 || bus.Rdata !== 8'h22) begin
      bad++;
      $display("FAIL bp_capture: Lack=%b LEreq=%b Rdata=%h want 1 1 22", bus.Lack, bus.LEreq, bus.Rdata);
    end
    wait_rreq(e, s);
    exp_d = sb.pop_front();
    total++;
    if (e - k !== 3 || bus.Rdata !== exp_d) begin
      bad++;
      $display("FAIL bp_second: Rreq at +%0d Rdata=%h want +3 %h", e - k, bus.Rdata, exp_d);
    end
    release_out();
  endtask
  task automatic test_back_to_back();
    int k, e, s, want;
    for (int i = 0; i < 4; i++) begin
      bus.Err1 = 1'($urandom_range(0, 1));
      bus.Err0 = !bus.Err1;
      want = bus.Err1 ? 4 : 3;
      capture(8'($urandom), k);
      wait_rreq(e, s);
      exp_d = sb.pop_front();
      total++;
      if (e - k !== want || bus.Rdata !== exp_d) begin
        bad++;
        $display("FAIL b2b_%0d: Rreq at +%0d Rdata=%h want +%0d %h", i, e - k, bus.Rdata, want, exp_d);
      end
      release_out();
    end
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_empty: %0d tokens left, want 0", sb.size());
    end
  endtask
  initial begin
    bus.Lreq  = 1'b0;
    bus.Ldata = 8'h00;
    bus.Rack  = 1'b0;
    bus.Err1  = 1'b0;
    bus.Err0  = 1'b0;
    test_reset();
    test_no_error();
    test_error();
    test_late_flag();
    test_saturation();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
